// File: rtl/stack_unit.sv
// Operand stack for the stack machine: entry storage, occupancy count and sticky fault flags.
// TOS/NOS/sp/empty/full decode combinationally; one stack operation commits per rising edge.
module stack_unit #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          op,
  input  logic [REG_BITS-1:0] wdata,
  input  logic                clr_err,
  output logic [REG_BITS-1:0] tos,
  output logic [REG_BITS-1:0] nos,
  output logic [CNT_BITS-2:0] sp,
  output logic [CNT_BITS-1:0] count,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
);

  localparam int IDX_BITS = CNT_BITS - 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_REPL = 3'b011;
  localparam logic [2:0] OP_BIN  = 3'b100;

  localparam logic [CNT_BITS-1:0] ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] TWO   = CNT_BITS'(2);
  localparam logic [CNT_BITS-1:0] CAP   = CNT_BITS'(DEPTH);

  logic [REG_BITS-1:0] mem_q [DEPTH];
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                we;
  logic [IDX_BITS-1:0] waddr;
  logic [IDX_BITS-1:0] tos_idx;
  logic [IDX_BITS-1:0] nos_idx;

  // Truncation makes the empty-stack sp come out as DEPTH-1 for free.
  assign tos_idx = IDX_BITS'(count_q - ONE);
  assign nos_idx = IDX_BITS'(count_q - TWO);

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CAP);
  assign sp        = tos_idx;
  assign tos       = empty ? '0 : mem_q[tos_idx];
  assign nos       = (count_q < TWO) ? '0 : mem_q[nos_idx];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    we          = 1'b0;
    waddr       = tos_idx;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          waddr   = IDX_BITS'(count_q);
          count_d = count_q + ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) count_d = count_q - ONE;
        else        underflow_d = 1'b1;
      end
      OP_REPL: begin
        if (!empty) begin
          we    = 1'b1;
          waddr = tos_idx;
        end else begin
          underflow_d = 1'b1;
        end
      end
      OP_BIN: begin
        if (count_q >= TWO) begin
          we      = 1'b1;
          waddr   = nos_idx;
          count_d = count_q - ONE;
        end else begin
          underflow_d = 1'b1;
        end
      end
      OP_NOP:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only suppresses the write in flight.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem_q[waddr] <= wdata;
  end

endmodule
